// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - pipelined adder/subtractor resolving WIDTH/STAGES bits per stage
// Each stage adds one chunk with the carry registered by the stage before it; valid/ready flow control.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             CO,
  output logic             OVF
);

  localparam int NS = (STAGES < 1) ? 1 : STAGES;
  localparam int C  = WIDTH / NS;

  generate
    if (STAGES < 1 || (WIDTH % NS) != 0) begin : g_bad_params
      $error("pipelined_adder: STAGES must be >= 1 and divide WIDTH");
    end
  endgenerate

  function automatic logic [C:0] add_chunk(input logic [C-1:0] x, input logic [C-1:0] y,
                                           input logic cin);
    return {1'b0, x} + {1'b0, y} + {{C{1'b0}}, cin};
  endfunction

  logic             s_valid [NS];
  logic [WIDTH-1:0] s_sum   [NS];
  logic [WIDTH-1:0] s_a     [NS];
  logic [WIDTH-1:0] s_b     [NS];
  logic             s_carry [NS];
  logic             s_sa    [NS];
  logic             s_sb    [NS];

  logic             n_valid [NS];
  logic [WIDTH-1:0] n_sum   [NS];
  logic [WIDTH-1:0] n_a     [NS];
  logic [WIDTH-1:0] n_b     [NS];
  logic             n_carry [NS];
  logic             n_sa    [NS];
  logic             n_sb    [NS];

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum_s;
  logic [C:0]       t;
  logic             adv;

  assign b_eff = Sub ? ~B : B;

  always_comb begin
    sum_s = '0;
    t     = add_chunk(A[C-1:0], b_eff[C-1:0], Sub);
    sum_s[C-1:0] = t[C-1:0];
    n_valid[0] = in_valid;
    n_sum[0]   = sum_s;
    n_a[0]     = A;
    n_b[0]     = b_eff;
    n_carry[0] = t[C];
    n_sa[0]    = A[WIDTH-1];
    n_sb[0]    = b_eff[WIDTH-1];
    for (int k = 1; k < NS; k++) begin
      t     = add_chunk(s_a[k-1][k*C +: C], s_b[k-1][k*C +: C], s_carry[k-1]);
      sum_s = s_sum[k-1];
      sum_s[k*C +: C] = t[C-1:0];
      n_valid[k] = s_valid[k-1];
      n_sum[k]   = sum_s;
      n_a[k]     = s_a[k-1];
      n_b[k]     = s_b[k-1];
      n_carry[k] = t[C];
      n_sa[k]    = s_sa[k-1];
      n_sb[k]    = s_sb[k-1];
    end
  end

  // The whole pipe moves as one: it only holds when the last stage is full and not consumed.
  assign adv      = out_ready || !out_valid;
  assign in_ready = adv;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int k = 0; k < NS; k++) begin
        s_valid[k] <= 1'b0;
        s_sum[k]   <= '0;
        s_a[k]     <= '0;
        s_b[k]     <= '0;
        s_carry[k] <= 1'b0;
        s_sa[k]    <= 1'b0;
        s_sb[k]    <= 1'b0;
      end
    end else if (adv) begin
      for (int k = 0; k < NS; k++) begin
        s_valid[k] <= n_valid[k];
        s_sum[k]   <= n_sum[k];
        s_a[k]     <= n_a[k];
        s_b[k]     <= n_b[k];
        s_carry[k] <= n_carry[k];
        s_sa[k]    <= n_sa[k];
        s_sb[k]    <= n_sb[k];
      end
    end
  end

  assign out_valid = s_valid[NS-1];
  assign Sum       = s_sum[NS-1];
  assign CO        = s_carry[NS-1];
  assign OVF       = (s_sa[NS-1] == s_sb[NS-1]) && (Sum[WIDTH-1] != s_sa[NS-1]);

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - directed and random checks of pipelined_adder (16 bits, 4 stages)
// A negedge monitor scoreboards every accepted operation against its emitted result.
module tb_pipelined_adder;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, sub, out_valid, out_ready, co, ovf;
  logic [W-1:0] a, b, sum;

  int           total = 0;
  int           bad = 0;
  logic [17:0]  exp_q [$];
  logic [17:0]  mon_exp;

  // directed vectors: {co, ovf, sum} worked out by hand
  logic [15:0]  ta [6] = '{16'h8888, 16'h6789, 16'h1234, 16'hFFFF, 16'h7FFF, 16'h0000};
  logic [15:0]  tb [6] = '{16'h8888, 16'hABCD, 16'h5678, 16'h0001, 16'h0001, 16'h0001};
  logic         ts [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [17:0]  te [6] = '{{2'b11, 16'h1110}, {2'b10, 16'h1356}, {2'b00, 16'hBBBC},
                           {2'b10, 16'h0000}, {2'b01, 16'h8000}, {2'b00, 16'hFFFF}};

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .Clk(clk), .Reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .Sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .Sum(sum), .CO(co), .OVF(ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic s);
    logic [15:0] yb;
    logic [16:0] f;
    yb = s ? ~y : y;
    f  = {1'b0, x} + {1'b0, yb} + {16'd0, s};
    return {f[16], (x[15] == yb[15]) && (f[15] != x[15]), f[15:0]};
  endfunction

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      exp_q.delete();
    end else begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("stream", {14'd0, co, ovf, sum}, {14'd0, mon_exp});
        end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) exp_q.push_back(model(a, b, sub));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_op(input logic [15:0] x, input logic [15:0] y, input logic s);
    int n = 0;
    in_valid = 1'b1; a = x; b = y; sub = s;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) check("push_timeout", 0, 1);
    step();
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    if (!out_valid) check({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b1; a = 16'h1234; b = 16'h0001; sub = 1'b0; out_ready = 1'b0;
    step();
    step();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", {co, ovf, sum}, 0);
    reset = 1'b0; in_valid = 1'b0;
    check("post_rst_in_ready", in_ready, 1);
    for (int i = 0; i < S + 2; i++) begin
      step();
      check("rst_input_dropped", out_valid, 0);
    end
    out_ready = 1'b1;

    // single operation, exact latency
    push_op(16'h3333, 16'h4444, 1'b0);
    in_valid = 1'b0;
    for (int i = 0; i < S - 1; i++) begin
      check("lat_early", out_valid, 0);
      step();
    end
    check("lat_valid", out_valid, 1);
    check("lat_result", {co, ovf, sum}, {2'b00, 16'h7777});
    step();
    check("lat_after", out_valid, 0);

    // back-to-back bursts of three: mixed signs, then boundaries
    for (int g = 0; g < 2; g++) begin
      for (int j = 0; j < 3; j++) push_op(ta[g*3+j], tb[g*3+j], ts[g*3+j]);
      in_valid = 1'b0;
      wait_valid("burst");
      for (int j = 0; j < 3; j++) begin
        check("burst_valid", out_valid, 1);
        check("burst_result", {co, ovf, sum}, te[g*3+j]);
        step();
      end
      check("burst_end", out_valid, 0);
    end

    // stall with a full pipe
    out_ready = 1'b0;
    for (int i = 0; i < S; i++) push_op(16'(i * 16'h1111), 16'h0001, 1'b0);
    in_valid = 1'b1; a = 16'h4444; b = 16'h0001; sub = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_in_ready", in_ready, 0);
      check("stall_valid", out_valid, 1);
      check("stall_sum", sum, 16'h0001);
      step();
    end
    out_ready = 1'b1;
    push_op(16'h4444, 16'h0001, 1'b0);
    push_op(16'h5555, 16'h0002, 1'b1);
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) step();
    check("stall_drained", exp_q.size(), 0);

    // reset with three operations in flight
    for (int j = 0; j < 3; j++) push_op(16'h1111, 16'(j + 1), 1'b0);
    in_valid = 1'b0; reset = 1'b1;
    step();
    check("flush_valid", out_valid, 0);
    reset = 1'b0;
    for (int i = 0; i < S + 4; i++) begin
      check("flush_stale", out_valid, 0);
      step();
    end

    // random stream against the scoreboard
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      a   = 16'($urandom());
      b   = 16'($urandom());
      sub = 1'($urandom_range(0, 1));
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("random_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
